// File: rtl/top_mult_pkg.sv
// ============================================================================
// Module      : top_mult_pkg
// Description : Shared defaults and width helper for the signed multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package top_mult_pkg;

  // Default operand widths (2x2 -> 4-bit product)
  localparam int WA_DEF = 2;
  localparam int WB_DEF = 2;

  // Smallest legal operand width: one sign bit plus one magnitude bit
  localparam int W_MIN = 2;

  // Full-precision product width. A signed WA x WB product always fits in
  // WA+WB bits, so the result can never overflow.
  function automatic int prod_width(input int wa, input int wb);
    return wa + wb;
  endfunction

endpackage

`default_nettype wire

// File: rtl/top_mult_array.sv
// ============================================================================
// Module      : top_mult_array
// Description : Combinational signed multiplier built as a sign-extended
//               shift-add array. Each row is A (sign-extended to the product
//               width) gated by one bit of B and shifted by that bit's weight.
//               The row for the sign bit of B has negative weight, so it is
//               subtracted instead of added.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module top_mult_array
  import top_mult_pkg::*;
#(
  parameter int WA = WA_DEF,
  parameter int WB = WB_DEF
) (
  input  logic signed [WA-1:0]    a,
  input  logic signed [WB-1:0]    b,
  output logic signed [WA+WB-1:0] p
);

  localparam int WP = prod_width(WA, WB);

  // A sign-extended once; every row reuses it
  logic signed [WP-1:0] a_ext;
  // Gated and shifted partial products, one per bit of B
  logic signed [WP-1:0] row [WB];
  // Running sum: acc[i] holds the sum of rows 0..i-1
  logic signed [WP-1:0] acc [WB+1];

  assign a_ext  = {{WB{a[WA-1]}}, a};
  assign acc[0] = '0;

  for (genvar i = 0; i < WB; i++) begin : g_row
    assign row[i] = b[i] ? (a_ext << i) : '0;

    if (i == WB - 1) begin : g_sign_row
      // Sign bit of B carries weight -2^(WB-1)
      assign acc[i+1] = acc[i] - row[i];
    end else begin : g_mag_row
      assign acc[i+1] = acc[i] + row[i];
    end
  end

  assign p = acc[WB];

endmodule

`default_nettype wire

// File: rtl/top_mult.sv
// ============================================================================
// Module      : top_mult
// Description : Signed two's-complement multiplier. P is the combinational
//               full-precision product; P_q/out_valid is a clocked copy of
//               the last accepted operand pair with a one-cycle valid pulse.
//               Optional macro TOP_MULT_PIPE_EN inserts an extra register
//               stage between the array and P_q (latency 2 instead of 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module top_mult
  import top_mult_pkg::*;
#(
  parameter int WA = WA_DEF,
  parameter int WB = WB_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WA-1:0]    A,
  input  logic signed [WB-1:0]    B,
  input  logic                    in_valid,
  output logic signed [WA+WB-1:0] P,
  output logic signed [WA+WB-1:0] P_q,
  output logic                    out_valid
);

  // Product width is derived, never a free parameter
  localparam int WP = prod_width(WA, WB);

  logic signed [WP-1:0] prod;

  top_mult_array #(
    .WA (WA),
    .WB (WB)
  ) u_array (
    .a (A),
    .b (B),
    .p (prod)
  );

  // Combinational path is independent of reset
  assign P = prod;

`ifdef TOP_MULT_PIPE_EN
  logic signed [WP-1:0] prod_s1;
  logic                 valid_s1;

  // First stage: capture the array output on accept, pass valid through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_s1  <= '0;
      valid_s1 <= 1'b0;
    end else begin
      valid_s1 <= in_valid;
      if (in_valid) begin
        prod_s1 <= prod;
      end
    end
  end

  // Output stage: bubbles in valid_s1 propagate unchanged, data holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      P_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= valid_s1;
      if (valid_s1) begin
        P_q <= prod_s1;
      end
    end
  end
`else
  // Output stage: capture on accept, valid is a one-cycle pulse per accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      P_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        P_q <= prod;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_top_mult.sv
// ============================================================================
// Module      : tb_top_mult
// Description : Directed self-checking bench for top_mult (2x2 default and a
//               4x3 instance). Honours TOP_MULT_PIPE_EN for latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_top_mult;

`ifdef TOP_MULT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;

  logic signed [1:0] A, B;
  logic              in_valid;
  logic signed [3:0] P, P_q;
  logic              out_valid;

  logic signed [3:0] a43;
  logic signed [2:0] b43;
  logic              iv43;
  logic signed [6:0] p43, pq43;
  logic              ov43;

  int vectors     = 0;
  int miscompares = 0;

  top_mult dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .P         (P),
    .P_q       (P_q),
    .out_valid (out_valid)
  );

  top_mult #(.WA(4), .WB(3)) dut43 (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a43),
    .B         (b43),
    .in_valid  (iv43),
    .P         (p43),
    .P_q       (pq43),
    .out_valid (ov43)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    logic signed [3:0] e;
    rst_n = 1'b0; in_valid = 1'b0; iv43 = 1'b0;
    A = 2'sd0; B = 2'sd0; a43 = 4'sd0; b43 = 3'sd0;
    #1;
    vectors++;
    if (P_q !== 4'sd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: P_q=%0d out_valid=%b, want 0/0", P_q, out_valid);
    end
    vectors++;
    if (pq43 !== 7'sd0 || ov43 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state43: P_q=%0d out_valid=%b, want 0/0", pq43, ov43);
    end
    // combinational path works while held in reset
    A = -2'sd2; B = -2'sd2; e = 4'sd4;
    #1;
    vectors++;
    if (P !== e) begin
      miscompares++;
      $display("FAIL reset_comb: P=%0d, want %0d", P, e);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exhaustive();
    // rows: A=-2,-1,0,1 ; columns: B=-2,-1,0,1
    int exp2 [16] = '{4, 2, 0, -2,  2, 1, 0, -1,  0, 0, 0, 0,  -2, -1, 0, 1};
    logic signed [3:0] e;
    in_valid = 1'b0;
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        @(negedge clk);
        A = 2'(ia - 2); B = 2'(ib - 2);
        e = 4'(exp2[ia*4 + ib]);
        #1;
        vectors++;
        if (P !== e) begin
          miscompares++;
          $display("FAIL exhaustive A=%0d B=%0d: P=%0d, want %0d", A, B, P, e);
        end
      end
    end
  endtask

  task automatic test_registered();
    logic signed [3:0] eq;
    logic              ev;
    @(negedge clk);
    A = -2'sd1; B = -2'sd2; in_valid = 1'b1;
    for (int cyc = 1; cyc <= LAT + 1; cyc++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      ev = (cyc == LAT);
      eq = (cyc >= LAT) ? 4'sd2 : 4'sd0;
      vectors++;
      if (out_valid !== ev || P_q !== eq) begin
        miscompares++;
        $display("FAIL registered cyc%0d: P_q=%0d out_valid=%b, want %0d/%b", cyc, P_q, out_valid, eq, ev);
      end
    end
  endtask

  task automatic test_hold();
    int ha [4] = '{1, -2, 0, -1};
    int hb [4] = '{-2, -1, 1, 1};
    int he [4] = '{-2, 2, 0, -1};
    logic signed [3:0] e;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      A = 2'(ha[k]); B = 2'(hb[k]); e = 4'(he[k]);
      #1;
      vectors++;
      if (P !== e || P_q !== 4'sd2 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL hold%0d: P=%0d P_q=%0d out_valid=%b, want %0d/2/0", k, P, P_q, out_valid, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int vv [6] = '{1, 1, 1, 1, 0, 1};
    int va [6] = '{1, -2, -2, -1, 0, 1};
    int vb [6] = '{1, -2, 1, -1, 0, -1};
    int ve [6] = '{1, 4, -2, 1, 0, -1};
    logic signed [3:0] hold;
    logic              ev;
    int                j;
    hold = 4'sd2;
    for (int k = 0; k < 6 + LAT; k++) begin
      @(negedge clk);
      if (k < 6) begin
        A = 2'(va[k]); B = 2'(vb[k]); in_valid = vv[k][0];
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      j = k - (LAT - 1);
      ev = 1'b0;
      if (j >= 0 && j < 6) begin
        ev = vv[j][0];
        if (vv[j] != 0) hold = 4'(ve[j]);
      end
      vectors++;
      if (out_valid !== ev || P_q !== hold) begin
        miscompares++;
        $display("FAIL back_to_back k%0d: P_q=%0d out_valid=%b, want %0d/%b", k, P_q, out_valid, hold, ev);
      end
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    A = 2'sd1; B = 2'sd1; in_valid = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    vectors++;
    if (P_q !== 4'sd1 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: P_q=%0d out_valid=%b, want 1/1", P_q, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (P_q !== 4'sd0 || out_valid !== 1'b0 || P !== 4'sd1) begin
      miscompares++;
      $display("FAIL reset_mid: P_q=%0d out_valid=%b P=%0d, want 0/0/1", P_q, out_valid, P);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    vectors++;
    if (P_q !== 4'sd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: P_q=%0d out_valid=%b, want 0/0", P_q, out_valid);
    end
  endtask

`ifdef TOP_MULT_PIPE_EN
  task automatic test_pipe();
    logic       ev [3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0] eq [3] = '{4'd0, 4'd1, 4'd1};
    @(negedge clk);
    A = 2'sd1; B = 2'sd1; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== ev[c] || P_q !== $signed(eq[c])) begin
        miscompares++;
        $display("FAIL pipe c%0d: P_q=%0d out_valid=%b, want %0d/%b", c, P_q, out_valid, eq[c], ev[c]);
      end
    end
  endtask
`endif

  task automatic test_wide();
    int wa [8] = '{-8, 7, -8, 7, -1, 0, 5, -3};
    int wb [8] = '{-4, 3, 3, -4, -1, -4, -3, 2};
    int we [8] = '{32, 21, -24, -28, 1, 0, -15, -6};
    logic signed [6:0] e;
    iv43 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a43 = 4'(wa[k]); b43 = 3'(wb[k]); e = 7'(we[k]);
      #1;
      vectors++;
      if (p43 !== e) begin
        miscompares++;
        $display("FAIL wide A=%0d B=%0d: P=%0d, want %0d", a43, b43, p43, e);
      end
    end
    for (int k = 0; k < 8; k++) begin
      int ra, rb;
      ra = int'($urandom_range(15)) - 8;
      rb = int'($urandom_range(7)) - 4;
      @(negedge clk);
      a43 = 4'(ra); b43 = 3'(rb); e = 7'(ra * rb);
      #1;
      vectors++;
      if (p43 !== e) begin
        miscompares++;
        $display("FAIL wide_rand A=%0d B=%0d: P=%0d, want %0d", a43, b43, p43, e);
      end
    end
    // registered corner: most negative times most negative
    @(negedge clk);
    a43 = -4'sd8; b43 = -3'sd4; iv43 = 1'b1;
    @(posedge clk); #1;
    iv43 = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    if (LAT > 1) #1;
    vectors++;
    if (pq43 !== 7'sd32 || ov43 !== 1'b1) begin
      miscompares++;
      $display("FAIL wide_reg: P_q=%0d out_valid=%b, want 32/1", pq43, ov43);
    end
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_registered();
    test_hold();
    test_back_to_back();
    test_reset_midstream();
`ifdef TOP_MULT_PIPE_EN
    test_pipe();
`endif
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net in case a wait never returns
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, want completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
